// File: rtl/pu_bitops.sv
// pu_bitops -- bitwise processing unit in the unique-ack chain.
//
// Purpose:
//   The unit executes AND/OR/XOR and their immediate forms with a registered
//   write-back (latency 1). When PU_BITOPS_COUNT_EN is defined, it also runs
//   POPCNT/CLZ on an iterative chunk counter. That counter consumes
//   OPTION_CNT_STEP bits per cycle, MSB first, and raises o_busy while it runs.
//   In the default build (macro undefined) POPCNT/CLZ are not claimed and
//   o_busy is tied low.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), async active-high reset
//   i_valid, i_opcode   instruction presented by the control unit
//   i_rega/b, i_regd    source/destination register numbers
//   i_imm               immediate, zero-extended to OPTION_REG_WIDTH
//   i_unique_ack        an upstream unit already claimed the instruction
//   o_unique_ack        this unit claims the instruction (combinational)
//   o_busy              count FSM occupied; the instruction must be held
//   o_sela/o_selb       register-file selects (pass-through)
//   o_write_*           registered write-back port, one strobe per result
//   i_ina/i_inb         register-file read data
module pu_bitops #(
  parameter int OPTION_REG_WIDTH    = 64,
  parameter int OPTION_OPCODE_WIDTH = 6,
  parameter int OPTION_IMM_WIDTH    = 16,
  parameter int OPTION_CNT_STEP     = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  input  logic [OPTION_OPCODE_WIDTH-1:0] i_opcode,
  input  logic [4:0]                     i_rega,
  input  logic [4:0]                     i_regb,
  input  logic [4:0]                     i_regd,
  input  logic [OPTION_IMM_WIDTH-1:0]    i_imm,
  input  logic                           i_unique_ack,
  output logic                           o_unique_ack,
  output logic                           o_busy,
  output logic [4:0]                     o_sela,
  output logic [4:0]                     o_selb,
  output logic [4:0]                     o_write_reg,
  output logic [OPTION_REG_WIDTH-1:0]    o_write_data,
  output logic                           o_write_en,
  input  logic [OPTION_REG_WIDTH-1:0]    i_ina,
  input  logic [OPTION_REG_WIDTH-1:0]    i_inb
);
  localparam int W = OPTION_REG_WIDTH;
  localparam int OW = OPTION_OPCODE_WIDTH;

  // Elaboration-time parameter sanity checks.
  if ((W < 8) || ((W & (W - 1)) != 0)) begin : g_chk_w
    $error("OPTION_REG_WIDTH must be a power of two >= 8");
  end
  if ((OPTION_CNT_STEP < 1) || (OPTION_CNT_STEP > W) || ((W % OPTION_CNT_STEP) != 0)) begin : g_chk_step
    $error("OPTION_CNT_STEP must divide OPTION_REG_WIDTH");
  end

  localparam logic [OW-1:0] OP_AND  = OW'(6'b000100);
  localparam logic [OW-1:0] OP_OR   = OW'(6'b000101);
  localparam logic [OW-1:0] OP_XOR  = OW'(6'b000110);
  localparam logic [OW-1:0] OP_ANDI = OW'(6'b000111);
  localparam logic [OW-1:0] OP_ORI  = OW'(6'b001000);
  localparam logic [OW-1:0] OP_XORI = OW'(6'b001001);

  assign o_sela = i_rega;
  assign o_selb = i_regb;

  // Decode
  logic       is_logic, is_imm, is_cnt, is_clz;
  logic [1:0] lop;  // 0 AND, 1 OR, 2 XOR

  always_comb begin
    is_logic = 1'b0;
    is_imm   = 1'b0;
    is_cnt   = 1'b0;
    is_clz   = 1'b0;
    lop      = 2'd0;
    case (i_opcode)
      OP_AND:  begin is_logic = 1'b1; lop = 2'd0; end
      OP_OR:   begin is_logic = 1'b1; lop = 2'd1; end
      OP_XOR:  begin is_logic = 1'b1; lop = 2'd2; end
      OP_ANDI: begin is_logic = 1'b1; lop = 2'd0; is_imm = 1'b1; end
      OP_ORI:  begin is_logic = 1'b1; lop = 2'd1; is_imm = 1'b1; end
      OP_XORI: begin is_logic = 1'b1; lop = 2'd2; is_imm = 1'b1; end
`ifdef PU_BITOPS_COUNT_EN
      OW'(6'b001010): is_cnt = 1'b1;
      OW'(6'b001011): begin is_cnt = 1'b1; is_clz = 1'b1; end
`endif
      default: ;
    endcase
  end

  // The claim ignores busy, so a held instruction is never taken by a later unit.
  assign o_unique_ack = i_valid & (is_logic | is_cnt) & ~i_unique_ack;
  logic accept;
  assign accept = o_unique_ack & ~o_busy;

  logic [W-1:0] opb, lres;
  assign opb = is_imm ? W'(i_imm) : i_inb;

  always_comb begin
    case (lop)
      2'd0:    lres = i_ina & opb;
      2'd1:    lres = i_ina | opb;
      default: lres = i_ina ^ opb;
    endcase
  end

  logic         wr_en_q;
  logic [4:0]   wr_reg_q;
  logic [W-1:0] wr_data_q;
  assign o_write_en   = wr_en_q;
  assign o_write_reg  = wr_reg_q;
  assign o_write_data = wr_data_q;

`ifdef PU_BITOPS_COUNT_EN
  localparam int STEP  = OPTION_CNT_STEP;
  localparam int NCH   = W / STEP;
  localparam int ACC_W = $clog2(W) + 1;
  localparam int CNT_W = $clog2(NCH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_WRITE} state_t;

  state_t           state_q;
  logic [W-1:0]     shreg_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q, done_d, clz_q;
  logic [4:0]       rd_q;
  logic [STEP-1:0]  chunk;
  logic [ACC_W-1:0] pc, lz;
  logic             found;

  assign o_busy = (state_q != S_IDLE);
  assign chunk  = shreg_q[W-1 -: STEP];

  // Per-chunk set-bit count and leading-zero count (MSB first).
  always_comb begin
    pc    = '0;
    lz    = '0;
    found = 1'b0;
    for (int i = STEP - 1; i >= 0; i--) begin
      if (chunk[i]) begin
        pc    = pc + ACC_W'(1);
        found = 1'b1;
      end else if (!found) begin
        lz = lz + ACC_W'(1);
      end
    end
    // CLZ freezes once any earlier chunk contained a one.
    if (clz_q) acc_d = done_q ? acc_q : acc_q + lz;
    else       acc_d = acc_q + pc;
    done_d = done_q | (|chunk);
  end
`else
  assign o_busy = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
`ifdef PU_BITOPS_COUNT_EN
      state_q <= S_IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      clz_q   <= 1'b0;
      rd_q    <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      if (accept && is_logic) begin
        wr_en_q   <= 1'b1;
        wr_reg_q  <= i_regd;
        wr_data_q <= lres;
      end
`ifdef PU_BITOPS_COUNT_EN
      case (state_q)
        S_IDLE: if (accept && is_cnt) begin
          shreg_q <= i_ina;
          rd_q    <= i_regd;
          acc_q   <= '0;
          done_q  <= 1'b0;
          clz_q   <= is_clz;
          cnt_q   <= CNT_W'(NCH);
          state_q <= S_COUNT;
        end
        S_COUNT: begin
          shreg_q <= shreg_q << STEP;
          acc_q   <= acc_d;
          done_q  <= done_d;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_WRITE;
        end
        S_WRITE: begin
          wr_en_q   <= 1'b1;
          wr_reg_q  <= rd_q;
          wr_data_q <= W'(acc_q);
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
`endif
    end
  end
endmodule
